// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
package wide_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wadd_state_t;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// master = operand source and result consumer, slave = the sequencer.
interface wide_add_sequencer_if
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
);

  localparam int W = WORD_W * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

endinterface

// File: rtl/prefix_add16_ci.sv
// 16-bit Sklansky prefix adder with carry-in; purely combinational.
module prefix_add16_ci (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [15:0] hp;
  logic [15:0] gg;
  logic [15:0] pp;

  // Generate/propagate, carry-in folded into bit 0, then four Sklansky levels.
  // In-place update is safe: the partner bit of every merge sits in the lower
  // half-block of that level, which is never rewritten at the same level.
  always_comb begin
    hp    = a ^ b;
    gg    = a & b;
    pp    = hp;
    gg[0] = gg[0] | (pp[0] & ci);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (((i >> l) & 1) == 1) begin
          gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
          pp[i] = pp[i] & pp[((i >> l) << l) - 1];
        end
      end
    end
    s  = hp ^ {gg[14:0], ci};
    co = gg[15];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract, one 16-bit word per cycle LSW first, through a single
// shared prefix adder. Subtract is A + ~B + 1: B is inverted at capture and
// the word carry starts at 1.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  wide_add_sequencer_if.slave bus
);

  localparam int W    = WORD_W * NWORDS;
  localparam int IDXW = $clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST = IDXW'(NWORDS - 1);

  wadd_state_t         state_q;
  wadd_state_t         state_d;
  logic [IDXW-1:0]     idx_q;
  logic                carry_q;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        sum_reg;
  logic                cout_reg;
  logic                ovf_reg;

  logic                accept;
  logic [IDXW+3:0]     bitoff;
  logic [WORD_W-1:0]   a_word;
  logic [WORD_W-1:0]   b_word;
  logic [WORD_W-1:0]   add_s;
  logic                add_co;

  // Signed overflow of the top word: like-signed operands, differently-signed result.
  function automatic logic ovf_flag(input logic signed [WORD_W-1:0] a,
                                    input logic signed [WORD_W-1:0] b,
                                    input logic signed [WORD_W-1:0] s);
    return (a[WORD_W-1] == b[WORD_W-1]) && (s[WORD_W-1] != a[WORD_W-1]);
  endfunction

  assign bitoff = {idx_q, 4'b0000};
  assign a_word = a_reg[bitoff +: WORD_W];
  assign b_word = b_reg[bitoff +: WORD_W];

  prefix_add16_ci u_add (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, word-serial accumulation and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.in_a;
      b_reg   <= bus.in_b ^ {W{bus.in_sub}};
      carry_q <= bus.in_sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_reg[bitoff +: WORD_W] <= add_s;
      carry_q                   <= add_co;
      if (idx_q == LAST) begin
        cout_reg <= add_co;
        ovf_reg  <= ovf_flag(a_word, b_word, add_s);
        idx_q    <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.out_sum  = sum_reg;
  assign bus.out_cout = cout_reg;
  assign bus.out_ovf  = ovf_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer (NWORDS=4): directed table, backpressure,
// mid-operation reset and randomized operations against a reference model.
module tb_wide_add_sequencer;

  localparam int NWORDS = 4;
  localparam int W      = 16 * NWORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wide_add_sequencer_if #(.NWORDS(NWORDS)) bus ();

  wide_add_sequencer #(.NWORDS(NWORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular / signed arithmetic on the whole W-bit values.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, output logic [W-1:0] s,
                                    output logic c, output logic v);
    logic [W:0]        u;
    logic signed [W:0] r;
    if (sub) begin
      s = a - b;
      c = (a >= b);
      r = $signed({a[W-1], a}) - $signed({b[W-1], b});
    end else begin
      u = {1'b0, a} + {1'b0, b};
      s = u[W-1:0];
      c = u[W];
      r = $signed({a[W-1], a}) + $signed({b[W-1], b});
    end
    v = (r[W] != r[W-1]);
  endfunction

  task automatic send(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub);
    check({name, "_in_ready"}, W'(bus.in_ready), W'(1));
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_sub   = ~sub;
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] es, input logic ec,
                             input logic ev);
    int cnt;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    check({name, "_latency"}, W'(cnt), W'(NWORDS));
    check({name, "_sum"}, bus.out_sum, es);
    check({name, "_cout"}, W'(bus.out_cout), W'(ec));
    check({name, "_ovf"}, W'(bus.out_ovf), W'(ev));
  endtask

  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_valid_clr"}, W'(bus.out_valid), W'(0));
    check({name, "_idle"}, W'(bus.in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb, rs, held;
    logic         rsub, rc, rv;
    int           hold;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    tbl[5] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};

    // Reset held for three cycles, then released.
    repeat (3) tick();
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_sum", bus.out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", W'(bus.in_ready), W'(1));
    check("rel_busy", W'(bus.busy), W'(0));
    check("rel_out_valid", W'(bus.out_valid), W'(0));
    check("rel_out_sum", bus.out_sum, '0);
    check("rel_out_cout", W'(bus.out_cout), W'(0));
    check("rel_out_ovf", W'(bus.out_ovf), W'(0));

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      send($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub);
      wait_result($sformatf("vec%0d", i), tbl[i].s, tbl[i].c, tbl[i].v);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held for 10 cycles while a new operand is offered.
    send("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    wait_result("bp", 64'h2222_2222_2222_2211, 1'b0, 1'b0);
    held          = bus.out_sum;
    bus.in_a      = 64'h0000_0000_0000_0010;
    bus.in_b      = 64'h0000_0000_0000_0020;
    bus.in_sub    = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", W'(bus.out_valid), W'(1));
      check("bp_sum", bus.out_sum, held);
      check("bp_cout", W'(bus.out_cout), W'(0));
      check("bp_ovf", W'(bus.out_ovf), W'(0));
      check("bp_in_ready", W'(bus.in_ready), W'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_rel_valid", W'(bus.out_valid), W'(0));
    check("bp_rel_ready", W'(bus.in_ready), W'(1));
    tick();
    bus.in_valid = 1'b0;
    check("bp_acc_busy", W'(bus.busy), W'(1));
    check("bp_acc_ready", W'(bus.in_ready), W'(0));
    wait_result("bp2", 64'h30, 1'b0, 1'b0);
    release_result("bp2");

    // Reset in the second RUN cycle, with a carry pending out of word 0.
    send("rmid", 64'h0000_0000_0000_FFFE, 64'h3, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rmid_valid", W'(bus.out_valid), W'(0));
    check("rmid_busy", W'(bus.busy), W'(0));
    check("rmid_ready", W'(bus.in_ready), W'(1));
    check("rmid_sum", bus.out_sum, '0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send("post", 64'h3, 64'h4, 1'b0);
    wait_result("post", 64'h7, 1'b0, 1'b0);
    release_result("post");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rsub = 1'($urandom_range(0, 1));
      if (i % 8 == 1) ra[W-1] = ~rb[W-1];
      if (i % 8 == 2) rb = ra;
      ref_model(ra, rb, rsub, rs, rc, rv);
      send($sformatf("rnd%0d", i), ra, rb, rsub);
      wait_result($sformatf("rnd%0d", i), rs, rc, rv);
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      check($sformatf("rnd%0d_hold", i), bus.out_sum, rs);
      release_result($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
